// File: rtl/systolic_pkg.sv
// systolic_pkg: shared constants and state encoding for the systolic sequencer
package systolic_pkg;
  localparam int ADDR_W        = 11;
  localparam int DATA_W        = 64;
  localparam int DIM           = 4;
  localparam int OUT_WORDS     = 4;
  localparam int DRAIN_CYC     = 2 * DIM - 2;
  localparam int ARRAY_OUT_LAT = 1;
  typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, UNLOAD, DONE} state_t;
endpackage

// File: rtl/seq_delay_line.sv
// seq_delay_line: N-cycle register pipeline for strobe/address alignment
module seq_delay_line #(
  parameter int N = 1,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [N];
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      for (int i = 0; i < N; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[N-1];
endmodule

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: load/feed/drain/unload sequencer for the 4x4 systolic top
module systolic_seq_ctrl
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic [ADDR_W-1:0] k_len,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              host_rd_en,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic              busy,
  output logic              done,
  output logic              input_en_ramin,
  output logic              wr_in,
  output logic [ADDR_W-1:0] adder_in,
  output logic [DATA_W-1:0] ram_din,
  output logic              input_en_sys,
  output logic              output_en_sys,
  output logic              input_en_ramout,
  output logic              wr_out,
  output logic [ADDR_W-1:0] adder_out
);
  state_t st, nxt;
  logic [ADDR_W-1:0] cnt, cnt_n, kl, ib, ob, uo_addr, wo_addr, hr_addr;
  logic hs, wr_go, rd_go, hr_go, hr, wo_en;
  assign hs    = ld_valid & ld_ready;
  assign wr_go = st == LOAD && hs;
  assign rd_go = st == FEED;
  assign hr_go = st == IDLE && host_rd_en && !start;
  always_comb begin
    nxt   = st;
    cnt_n = cnt + ADDR_W'(1);
    case (st)
      IDLE: begin
        cnt_n = '0;
        if (start) nxt = (k_len == '0) ? DONE : LOAD;
      end
      LOAD: begin
        cnt_n = hs ? cnt + ADDR_W'(1) : cnt;
        if (hs && cnt == kl - ADDR_W'(1)) begin
          nxt   = FEED;
          cnt_n = '0;
        end
      end
      FEED: if (cnt == kl - ADDR_W'(1)) begin
        nxt   = DRAIN;
        cnt_n = '0;
      end
      // first DRAIN cycle carries the last read; the array sees it one cycle later
      DRAIN: if (cnt == ADDR_W'(DRAIN_CYC + 1)) begin
        nxt   = UNLOAD;
        cnt_n = '0;
      end
      UNLOAD: if (cnt == ADDR_W'(OUT_WORDS + ARRAY_OUT_LAT - 1)) nxt = DONE;
      DONE: begin
        nxt   = IDLE;
        cnt_n = '0;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      st             <= IDLE;
      cnt            <= '0;
      kl             <= '0;
      ib             <= '0;
      ob             <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      ld_ready       <= 1'b0;
      input_en_ramin <= 1'b0;
      wr_in          <= 1'b0;
      adder_in       <= '0;
      ram_din        <= '0;
      output_en_sys  <= 1'b0;
      uo_addr        <= '0;
      hr             <= 1'b0;
      hr_addr        <= '0;
    end else begin
      st             <= nxt;
      cnt            <= cnt_n;
      busy           <= nxt != IDLE;
      done           <= nxt == DONE;
      ld_ready       <= nxt == LOAD;
      input_en_ramin <= wr_go || rd_go;
      wr_in          <= wr_go;
      output_en_sys  <= nxt == UNLOAD && cnt_n < ADDR_W'(OUT_WORDS);
      uo_addr        <= ob + cnt_n;
      hr             <= hr_go;
      if (st == IDLE && start) begin
        kl <= k_len;
        ib <= in_base;
        ob <= out_base;
      end
      if (wr_go || rd_go) adder_in <= ib + cnt;
      if (wr_go) ram_din <= ld_data;
      if (hr_go) hr_addr <= host_rd_addr;
    end
  seq_delay_line #(.N(1), .W(1)) u_sys (
    .clk  (clk),
    .rst_b(rst_b),
    .d    (input_en_ramin & ~wr_in),
    .q    (input_en_sys)
  );
  seq_delay_line #(.N(ARRAY_OUT_LAT), .W(ADDR_W + 1)) u_out (
    .clk  (clk),
    .rst_b(rst_b),
    .d    ({output_en_sys, uo_addr}),
    .q    ({wo_en, wo_addr})
  );
  // unload writes and host reads never overlap: host reads are only taken in IDLE
  assign input_en_ramout = wo_en | hr;
  assign wr_out          = wo_en;
  assign adder_out       = wo_en ? wo_addr : hr_addr;
endmodule
